counter_gray_updown: RTL and testbench

Parametrised N-bit synchronous up/down counter that produces a registered Gray-code count and its binary equivalent, both valid in the same cycle. It adds count enable, direction control, parallel load in binary or Gray, and a terminal-count pulse. It is the general-purpose Gray counter for the counters library and serves as the pointer generator for clock-domain-crossing FIFOs.

---
 rtl/counter_pkg.sv | 19 +
 rtl/gray2bin_dec.sv | 11 +
 rtl/counter_gray_updown.sv | 52 +++++
 tb/tb_counter_gray_updown.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and width-parametrised Gray/binary conversions
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [63:0] width_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction
  function automatic logic [63:0] bin2gray(input logic [63:0] b, input int w);
    logic [63:0] m;
    m = b & width_mask(w);
    return m ^ (m >> 1);
  endfunction
  function automatic logic [63:0] gray2bin(input logic [63:0] g, input int w);
    logic [63:0] r;
    r = g & width_mask(w);
    for (int i = 62; i >= 0; i--) r[i] = r[i + 1] ^ r[i];
    return r;
  endfunction
endpackage

// File: rtl/gray2bin_dec.sv
// gray2bin_dec: combinational N-bit Gray-to-binary decoder; each bit is the XOR of all Gray bits at or above it
module gray2bin_dec #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);
  for (genvar g = 0; g < N; g++) begin : g_bit
    assign o_bin[g] = ^i_gray[N-1:g];
  end
endmodule

// File: rtl/counter_gray_updown.sv
// counter_gray_updown: N-bit up/down counter with registered binary and Gray outputs; COUNTER_GRAY_SAT_EN selects saturating instead of wrapping
module counter_gray_updown
  import counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         en_in,
  input  logic         up_in,
  input  logic         load_in,
  input  logic         load_gray_in,
  input  logic [N-1:0] load_val_in,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         tc_out
);
  logic [N-1:0] r_bin, r_gray;
  logic         r_tc;
  logic [N-1:0] w_dec, w_load_bin, w_step, w_cnt, w_next, w_next_gray;
  logic         w_at_bound, w_tc;
  gray2bin_dec #(.N(N)) u_dec (.i_gray(load_val_in), .o_bin(w_dec));
  // next-state selection: load beats count beats hold; boundary detect drives tc and saturation
  always_comb begin
    w_load_bin = load_gray_in ? w_dec : load_val_in;
    w_at_bound = (up_in == DIR_UP) ? &r_bin : ~|r_bin;
    w_step = (up_in == DIR_UP) ? r_bin + N'(1) : r_bin - N'(1);
`ifdef COUNTER_GRAY_SAT_EN
    w_cnt = w_at_bound ? r_bin : w_step;
`else
    w_cnt = w_step;
`endif
    w_next = load_in ? w_load_bin : en_in ? w_cnt : r_bin;
    w_next_gray = N'(bin2gray(64'(w_next), N));
    w_tc = !load_in && en_in && w_at_bound;
  end
  // both count registers load from the same next value so Gray never lags binary
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_bin <= '0;
      r_gray <= '0;
      r_tc <= 1'b0;
    end else begin
      r_bin <= w_next;
      r_gray <= w_next_gray;
      r_tc <= w_tc;
    end
  end
  assign bin_out = r_bin;
  assign gray_out = r_gray;
  assign tc_out = r_tc;
endmodule

// File: tb/tb_counter_gray_updown.sv
// tb_counter_gray_updown: directed self-checking bench for the N=4 Gray up/down counter
module tb_counter_gray_updown;
  logic       clk = 1'b0;
  logic       reset_al_in = 1'b0;
  logic       en_in = 1'b0;
  logic       up_in = 1'b1;
  logic       load_in = 1'b0;
  logic       load_gray_in = 1'b0;
  logic [3:0] load_val_in = 4'd0;
  logic [3:0] bin_out, gray_out;
  logic       tc_out;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] gt [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  counter_gray_updown #(.N(4)) dut (
    .clk(clk), .reset_al_in(reset_al_in), .en_in(en_in), .up_in(up_in), .load_in(load_in),
    .load_gray_in(load_gray_in), .load_val_in(load_val_in), .bin_out(bin_out), .gray_out(gray_out),
    .tc_out(tc_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({bin_out, gray_out, tc_out} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset: bin=%b gray=%b tc=%b, want 0000 0000 0", bin_out, gray_out, tc_out);
    end
    reset_al_in = 1'b1;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_hold: bin=%b gray=%b tc=%b, want 0000 0000 0", bin_out, gray_out, tc_out);
    end
  endtask

  task automatic test_count_up();
    en_in = 1'b1;
    up_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      vectors++;
      if ({bin_out, gray_out, tc_out} !== {4'(i % 16), gt[i % 16], i == 16}) begin
        miscompares++;
        $display("FAIL count_up[%0d]: bin=%b gray=%b tc=%b, want %b %b %b", i, bin_out, gray_out, tc_out,
                 4'(i % 16), gt[i % 16], i == 16);
      end
    end
    en_in = 1'b0;
  endtask

  task automatic test_load_bin_down();
    logic [3:0] exp_b [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
    load_in = 1'b1;
    load_gray_in = 1'b0;
    load_val_in = 4'd5;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd5, 4'b0111, 1'b0}) begin
      miscompares++;
      $display("FAIL load_bin5: bin=%b gray=%b tc=%b, want 0101 0111 0", bin_out, gray_out, tc_out);
    end
    load_in = 1'b0;
    en_in = 1'b1;
    up_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if ({bin_out, gray_out, tc_out} !== {exp_b[i], gt[exp_b[i]], i == 5}) begin
        miscompares++;
        $display("FAIL count_down[%0d]: bin=%b gray=%b tc=%b, want %b %b %b", i, bin_out, gray_out, tc_out,
                 exp_b[i], gt[exp_b[i]], i == 5);
      end
    end
    en_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd15, 4'b1000, 1'b0}) begin
      miscompares++;
      $display("FAIL hold: bin=%b gray=%b tc=%b, want 1111 1000 0", bin_out, gray_out, tc_out);
    end
  endtask

  task automatic test_load_gray();
    load_in = 1'b1;
    load_gray_in = 1'b1;
    load_val_in = 4'b1100;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd8, 4'b1100, 1'b0}) begin
      miscompares++;
      $display("FAIL load_gray1100: bin=%b gray=%b tc=%b, want 1000 1100 0", bin_out, gray_out, tc_out);
    end
    load_val_in = 4'b1000;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd15, 4'b1000, 1'b0}) begin
      miscompares++;
      $display("FAIL load_gray1000: bin=%b gray=%b tc=%b, want 1111 1000 0", bin_out, gray_out, tc_out);
    end
    load_val_in = 4'b0110;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd4, 4'b0110, 1'b0}) begin
      miscompares++;
      $display("FAIL load_gray0110: bin=%b gray=%b tc=%b, want 0100 0110 0", bin_out, gray_out, tc_out);
    end
    load_in = 1'b0;
    load_gray_in = 1'b0;
  endtask

  task automatic test_load_priority();
    load_in = 1'b1;
    en_in = 1'b1;
    up_in = 1'b1;
    load_val_in = 4'd3;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd3, 4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL load_over_en: bin=%b gray=%b tc=%b, want 0011 0010 0", bin_out, gray_out, tc_out);
    end
    load_val_in = 4'd15;
    step();
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd15, 4'b1000, 1'b0}) begin
      miscompares++;
      $display("FAIL load_at_top: bin=%b gray=%b tc=%b, want 1111 1000 0", bin_out, gray_out, tc_out);
    end
    load_in = 1'b0;
    en_in = 1'b0;
  endtask

  task automatic test_direction_change();
    logic       dir [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_b [4] = '{4'd4, 4'd5, 4'd4, 4'd5};
    load_in = 1'b1;
    load_val_in = 4'd3;
    step();
    load_in = 1'b0;
    en_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_in = dir[i];
      step();
      vectors++;
      if ({bin_out, gray_out, tc_out} !== {exp_b[i], gt[exp_b[i]], 1'b0}) begin
        miscompares++;
        $display("FAIL dir_change[%0d]: bin=%b gray=%b tc=%b, want %b %b 0", i, bin_out, gray_out, tc_out,
                 exp_b[i], gt[exp_b[i]]);
      end
    end
    en_in = 1'b0;
  endtask

  task automatic test_async_reset();
    load_in = 1'b1;
    load_val_in = 4'd9;
    step();
    load_in = 1'b0;
    vectors++;
    if (bin_out !== 4'd9) begin
      miscompares++;
      $display("FAIL pre_reset: bin=%b, want 1001", bin_out);
    end
    #1 reset_al_in = 1'b0;
    #1;
    vectors++;
    if ({bin_out, gray_out, tc_out} !== 9'b0) begin
      miscompares++;
      $display("FAIL async_reset: bin=%b gray=%b tc=%b, want 0000 0000 0", bin_out, gray_out, tc_out);
    end
    #1 reset_al_in = 1'b1;
    en_in = 1'b1;
    up_in = 1'b1;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd1, 4'b0001, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset_step: bin=%b gray=%b tc=%b, want 0001 0001 0", bin_out, gray_out, tc_out);
    end
    en_in = 1'b0;
  endtask

`ifdef COUNTER_GRAY_SAT_EN
  task automatic test_boundary();
    load_in = 1'b1;
    load_val_in = 4'd15;
    step();
    load_in = 1'b0;
    en_in = 1'b1;
    up_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bin_out, gray_out, tc_out} !== {4'd15, 4'b1000, 1'b1}) begin
        miscompares++;
        $display("FAIL sat_top[%0d]: bin=%b gray=%b tc=%b, want 1111 1000 1", i, bin_out, gray_out, tc_out);
      end
    end
    up_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd14, 4'b1001, 1'b0}) begin
      miscompares++;
      $display("FAIL sat_leave: bin=%b gray=%b tc=%b, want 1110 1001 0", bin_out, gray_out, tc_out);
    end
    load_in = 1'b1;
    load_val_in = 4'd0;
    step();
    load_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd0, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL sat_bottom: bin=%b gray=%b tc=%b, want 0000 0000 1", bin_out, gray_out, tc_out);
    end
    en_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd0, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL sat_idle: bin=%b gray=%b tc=%b, want 0000 0000 0", bin_out, gray_out, tc_out);
    end
  endtask
`else
  task automatic test_boundary();
    load_in = 1'b1;
    load_val_in = 4'd15;
    step();
    load_in = 1'b0;
    en_in = 1'b1;
    up_in = 1'b1;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd0, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_up: bin=%b gray=%b tc=%b, want 0000 0000 1", bin_out, gray_out, tc_out);
    end
    up_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd15, 4'b1000, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_down: bin=%b gray=%b tc=%b, want 1111 1000 1", bin_out, gray_out, tc_out);
    end
    up_in = 1'b1;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd0, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_again: bin=%b gray=%b tc=%b, want 0000 0000 1", bin_out, gray_out, tc_out);
    end
    en_in = 1'b0;
    step();
    vectors++;
    if ({bin_out, gray_out, tc_out} !== {4'd0, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_idle: bin=%b gray=%b tc=%b, want 0000 0000 0", bin_out, gray_out, tc_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_load_bin_down();
    test_load_gray();
    test_load_priority();
    test_direction_change();
    test_async_reset();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
